// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel emits a 50% duty square wave with a
// runtime-writable half-period divisor, plus a one-cycle tick on every rising output edge.
module clk_div_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 26,
    parameter int unsigned DEF_DIV = 50000000,
    parameter int unsigned CH_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0]  div_q   [NUM_CH];
    logic [CNT_W-1:0]  div_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  eff_div [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wr_hit;

    always_comb begin
        clk_out_d = clk_out_q;
        tick_d    = '0;
        wr_hit    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            cnt_d[i]   = cnt_q[i];
            // Only indices below NUM_CH can match, so out-of-range writes fall through.
            wr_hit[i]  = wr_en && (wr_ch == CH_W'(i));
            eff_div[i] = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];

            if (wr_hit[i]) begin
                div_d[i] = wr_div;
            end

            if (sync || !ch_en[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
            end else if (wr_hit[i]) begin
                // Restart the half-period from the new divisor; output level is held.
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= eff_div[i] - CNT_W'(1)) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = ~clk_out_q[i];
                tick_d[i]    = ~clk_out_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DefDiv;
                cnt_q[i] <= '0;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a 4-channel and a 3-channel build driven by shared stimulus, checked
// against an arithmetic reference model, a vector table and hand-written corner sequences.
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_div = '0;
    logic [3:0] ch_en = '0;
    logic       sync = 1'b0;
    logic [3:0] clk_out4, tick4;
    logic [2:0] clk_out3, tick3;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    clk_div_multi #(.NUM_CH(4), .CNT_W(8), .DEF_DIV(3), .CH_W(2)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .ch_en(ch_en), .sync(sync), .clk_out(clk_out4), .tick(tick4)
    );

    clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(3), .CH_W(2)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .ch_en(ch_en[2:0]), .sync(sync), .clk_out(clk_out3), .tick(tick3)
    );

    // Model: each channel remembers its level at the last restart and how many counting edges
    // have passed since; the output follows from integer division by the effective divisor.
    int unsigned m_div [4];
    longint      m_n   [4];
    logic        m_lvl [4];

    function automatic int unsigned m_eff(input int i);
        return (m_div[i] == 0) ? 1 : m_div[i];
    endfunction

    function automatic logic m_out(input int i);
        return m_lvl[i] ^ logic'((m_n[i] / m_eff(i)) % 2);
    endfunction

    function automatic logic m_tick(input int i);
        return (m_n[i] > 0) && (m_n[i] % m_eff(i) == 0) && m_out(i);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            logic cur;
            logic hit;
            cur = m_out(i);
            hit = wr_en && (int'(wr_ch) == i);
            if (rst) begin
                m_div[i] = 3; m_n[i] = 0; m_lvl[i] = 1'b0;
            end else begin
                if (sync || !ch_en[i]) begin
                    m_n[i] = 0; m_lvl[i] = 1'b0;
                end else if (hit) begin
                    m_n[i] = 0; m_lvl[i] = cur;
                end else begin
                    m_n[i]++;
                end
                if (hit) m_div[i] = int'(wr_div);
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act_c, input logic [3:0] act_t,
                       input logic [3:0] exp_c, input logic [3:0] exp_t);
        total_cnt++;
        if (act_c === exp_c && act_t === exp_t) pass_cnt++;
        else $display("FAIL %s: got clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                      name, act_c, act_t, exp_c, exp_t);
    endtask

    // One clock edge with the current inputs, then both builds compared against the model.
    task automatic step();
        logic [3:0] ec, et;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 4; i++) begin
            ec[i] = m_out(i);
            et[i] = m_tick(i);
        end
        chk("model4", clk_out4, tick4, ec, et);
        chk("model3", {1'b0, clk_out3}, {1'b0, tick3}, {1'b0, ec[2:0]}, {1'b0, et[2:0]});
    endtask

    task automatic set_in(input logic r, input logic we, input logic [1:0] wc,
                          input logic [7:0] wd, input logic [3:0] en, input logic s);
        rst = r; wr_en = we; wr_ch = wc; wr_div = wd; ch_en = en; sync = s;
    endtask

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_div;
        logic [3:0] ch_en;
        logic       sync;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
    } vec_t;

    vec_t vecs [16];

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_div[i] = 3; m_n[i] = 0; m_lvl[i] = 1'b0;
        end

        // Reset, ch0 at default divisor 3, then ch2 written to 0 and enabled.
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0001, 4'b0001};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0001, 4'b0000};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0001, 4'b0000};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0, 4'b0001, 4'b0001};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 8'd0, 4'b0001, 1'b0, 4'b0001, 4'b0000};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0101, 1'b0, 4'b0101, 4'b0100};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0101, 1'b0, 4'b0000, 4'b0000};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0101, 1'b0, 4'b0100, 4'b0100};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0101, 1'b0, 4'b0000, 4'b0000};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0101, 1'b0, 4'b0101, 4'b0101};

        for (int v = 0; v < 16; v++) begin
            set_in(vecs[v].rst, vecs[v].wr_en, vecs[v].wr_ch, vecs[v].wr_div, vecs[v].ch_en,
                   vecs[v].sync);
            step();
            chk($sformatf("vec%0d", v), clk_out4, tick4, vecs[v].exp_clk, vecs[v].exp_tick);
        end

        // Divisor rewrite on ch1 exactly at its terminal count.
        set_in(1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0); step();
        for (int k = 1; k <= 18; k++) begin
            logic hi, tk;
            if (k == 3) set_in(1'b0, 1'b1, 2'd1, 8'd5, 4'b0010, 1'b0);
            else        set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 1'b0);
            step();
            hi = (k >= 8 && k < 13) || (k >= 18);
            tk = (k == 8) || (k == 18);
            chk($sformatf("rewrite_k%0d", k), clk_out4, tick4, {2'b00, hi, 1'b0},
                {2'b00, tk, 1'b0});
        end

        // All channels at 3,4,5,6, then a sync pulse realigns them.
        set_in(1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0); step();
        for (int c = 0; c < 4; c++) begin
            set_in(1'b0, 1'b1, 2'(c), 8'(c + 3), 4'b0000, 1'b0); step();
        end
        for (int k = 0; k < 7; k++) begin
            set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 1'b0); step();
        end
        set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 1'b1); step();
        chk("sync_clear", clk_out4, tick4, 4'b0000, 4'b0000);
        for (int k = 1; k <= 6; k++) begin
            logic [3:0] ec, et;
            set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 1'b0); step();
            for (int c = 0; c < 4; c++) begin
                ec[c] = (k >= c + 3) && (k < 2 * (c + 3));
                et[c] = (k == c + 3);
            end
            chk($sformatf("sync_k%0d", k), clk_out4, tick4, ec, et);
        end

        // Out-of-range write on the 3-channel build, then reset mid-period.
        set_in(1'b0, 1'b1, 2'd3, 8'd1, 4'b1111, 1'b0); step();
        set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 1'b0); step(); step();
        set_in(1'b1, 1'b0, 2'd0, 8'd0, 4'b1111, 1'b0); step();
        chk("rst_mid", clk_out4, tick4, 4'b0000, 4'b0000);

        // Disable while high, then re-enable.
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0); step();
        end
        chk("pre_disable_high", clk_out4, tick4, 4'b0001, 4'b0000);
        set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0); step();
        chk("disable", clk_out4, tick4, 4'b0000, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0); step();
            chk($sformatf("reenable_k%0d", k), clk_out4, tick4, {3'b000, k == 3},
                {3'b000, k == 3});
        end

        // Randomised traffic checked against the model only.
        for (int k = 0; k < 2000; k++) begin
            logic [3:0] en;
            en = ch_en;
            if ($urandom_range(15) == 0) en = 4'($urandom);
            set_in($urandom_range(63) == 0, $urandom_range(7) == 0, 2'($urandom_range(3)),
                   8'($urandom_range(7)), en, $urandom_range(31) == 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Parameters
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent divider channels (legal range 1..16).
REQ-002 The block SHALL have parameter CNT_W, default 26, giving the width of each half-period divisor and counter.
REQ-003 The block SHALL have parameter DEF_DIV, default 50000000, giving the reset divisor for every channel (1 Hz from 100 MHz).
REQ-004 The block SHALL have parameter CH_W, default 2, giving the channel-select width, with NUM_CH <= 2^CH_W.

Interface
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_en  input  1  divisor write strobe, one write per asserted cycle.
REQ-008 wr_ch  input  CH_W  channel index for the write.
REQ-009 wr_div  input  CNT_W  new half-period divisor, in clk cycles.
REQ-010 ch_en  input  NUM_CH  per-channel run enable.
REQ-011 sync  input  1  phase-align pulse for all channels.
REQ-012 clk_out  output  NUM_CH  per-channel 50% duty square wave, registered.
REQ-013 tick  output  NUM_CH  per-channel one-cycle pulse, registered.

Function
REQ-014 Each channel SHALL hold a divisor register div[i] (CNT_W bits) and a counter cnt[i] (CNT_W bits).
REQ-015 An effective divisor of 0 SHALL behave as 1, so the channel toggles every cycle.
REQ-016 Channel i SHALL count only when ch_en[i]=1: if cnt[i] != eff_div-1, then cnt[i] <= cnt[i]+1; else cnt[i] <= 0 and clk_out[i] toggles.
REQ-017 The resulting clk_out[i] period SHALL be 2*eff_div clk cycles with exactly 50% duty.
REQ-018 tick[i] SHALL be 1 for exactly the cycle after clk_out[i] toggles 0->1, and 0 otherwise (one tick per output period).
REQ-019 When ch_en[i]=0, the channel SHALL set cnt[i] <= 0, clk_out[i] <= 0 and tick[i] <= 0.
REQ-020 On re-enable, the first rising toggle SHALL occur on the eff_div-th enabled edge.
REQ-021 A write (wr_en=1, wr_ch<NUM_CH) SHALL set div[wr_ch] <= wr_div and cnt[wr_ch] <= 0, leave clk_out[wr_ch] unchanged, and produce no toggle that cycle.
REQ-022 If a write and terminal count coincide on the same channel, the write SHALL win.
REQ-023 A write with wr_ch >= NUM_CH SHALL be ignored and leave all state unchanged.
REQ-024 Writes SHALL be accepted regardless of ch_en.
REQ-025 sync=1 SHALL clear all cnt, clk_out and tick to 0, leave div unchanged, and take priority over writes to cnt.
REQ-026 A div write in the same cycle as sync SHALL still update div.
REQ-027 Counter arithmetic SHALL be unsigned CNT_W-bit, and a counter SHALL never exceed eff_div-1.
REQ-028 Channels SHALL be fully independent: no cross-channel coupling except sync and rst.

Reset
REQ-029 While rst=1 at a clock edge: div[*] <= DEF_DIV truncated to CNT_W; cnt[*] <= 0; clk_out <= 0; tick <= 0.
REQ-030 rst SHALL override sync, writes and ch_en.
REQ-031 Reset asserted mid-period SHALL abort the period with no residual tick.

Verification (NUM_CH=4, CNT_W=8, DEF_DIV=3, CH_W=2)
REQ-032 Reset then ch_en=4'b0001 -> clk_out[0] rises on the 3rd enabled edge, period 6 cycles; tick[0] high 1 cycle per 6; other channels stay 0.
REQ-033 Write ch2 div=0 then ch_en[2]=1 -> clk_out[2] toggles every cycle (period 2); tick[2] every 2nd cycle.
REQ-034 Ch1 running div=3; at cnt=2 write wr_ch=1 wr_div=5 -> no toggle that cycle, clk_out[1] held, next toggle 5 edges later, period 10 from then on.
REQ-035 All four channels enabled with divisors 3,4,5,6; pulse sync once -> all clk_out=0 next cycle; rising edges 3,4,5,6 edges later; div values unchanged.
REQ-036 wr_ch=3 on NUM_CH=3 build -> no state change; rst pulsed mid-period on ch0 -> clk_out=0, tick=0, cnt=0 next cycle, div[*]=3.
REQ-037 ch_en[0] dropped while clk_out[0]=1 -> clk_out[0]=0 and tick[0]=0 next cycle; re-enable gives the first rise on the 3rd enabled edge.
